// File: rtl/ws2812_rx_decoder_if.sv
// Signal bundle between the WS2812 NZR receiver and whatever consumes its pixels.
// master = decoder side, slave = consumer / stimulus side.
interface ws2812_rx_decoder_if;
   logic        dataIn;
   logic [23:0] pixelGRB;
   logic        pixelValid;
   logic [7:0]  pixelIndex;
   logic        frameDone;
   logic [7:0]  pixelCount;
   logic        frameErr;
   logic        armed;

   modport master (
      input  dataIn,
      output pixelGRB, pixelValid, pixelIndex, frameDone, pixelCount, frameErr, armed
   );

   modport slave (
      output dataIn,
      input  pixelGRB, pixelValid, pixelIndex, frameDone, pixelCount, frameErr, armed
   );
endinterface

// File: rtl/ws2812_rx_decoder.sv
// WS2812B NZR receiver: decodes bits from high-pulse width, assembles 24-bit GRB
// words MSB first, and reports end of frame on the long low reset code.
module ws2812_rx_decoder #(
   parameter int T_THRESH  = 60,
   parameter int T_MINHIGH = 20,
   parameter int T_MAXHIGH = 120,
   parameter int T_RESET   = 28000,
   parameter int CW        = 15
) (
   input  logic clk,
   input  logic reset,
   ws2812_rx_decoder_if.master bus
);

   typedef enum logic [1:0] {WAIT_RST, IDLE, HIGH, LOW} state_t;

   state_t         state_reg, state_next;
   logic [1:0]     sync_reg;
   logic           ds_d_reg;
   logic [CW-1:0]  tcnt_reg;
   logic [23:0]    shift_reg;
   logic [4:0]     bit_cnt_reg;
   logic [7:0]     pix_cnt_reg;
   logic [23:0]    pixel_grb_reg;
   logic           pixel_valid_reg;
   logic [7:0]     pixel_index_reg;
   logic           frame_done_reg;
   logic [7:0]     pixel_count_reg;
   logic           frame_err_reg;

   logic ds, rise, fall;
   logic bit_val;
   logic start_frame, take_bit, set_err, end_frame;
   logic [23:0] shift_next;

   assign ds         = sync_reg[1];
   assign rise       = ds & ~ds_d_reg;
   assign fall       = ~ds & ds_d_reg;
   assign bit_val    = (tcnt_reg >= CW'(T_THRESH));
   assign shift_next = {shift_reg[22:0], bit_val};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= 2'b00;
         ds_d_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], bus.dataIn};
         ds_d_reg <= ds;
      end
   end

   // The edge cycle loads 1, so on the next edge tcnt equals the previous level's length.
   always_ff @(posedge clk) begin
      if (reset)
         tcnt_reg <= '0;
      else if (state_reg == WAIT_RST && ds)
         tcnt_reg <= '0;
      else if (rise || fall)
         tcnt_reg <= CW'(1);
      else if (tcnt_reg != CW'(T_RESET))
         tcnt_reg <= tcnt_reg + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= WAIT_RST;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      start_frame = 1'b0;
      take_bit    = 1'b0;
      set_err     = 1'b0;
      end_frame   = 1'b0;
      case (state_reg)
         WAIT_RST: begin
            if (!ds && tcnt_reg >= CW'(T_RESET))
               state_next = IDLE;
         end
         IDLE: begin
            if (rise) begin
               start_frame = 1'b1;
               state_next  = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               if (tcnt_reg < CW'(T_MINHIGH)) begin
                  set_err    = 1'b1;
                  state_next = WAIT_RST;
               end else begin
                  take_bit   = 1'b1;
                  state_next = LOW;
               end
            end else if (tcnt_reg >= CW'(T_MAXHIGH)) begin
               set_err    = 1'b1;
               state_next = WAIT_RST;
            end
         end
         LOW: begin
            if (rise)
               state_next = HIGH;
            else if (tcnt_reg >= CW'(T_RESET)) begin
               end_frame  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = WAIT_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg       <= '0;
         bit_cnt_reg     <= '0;
         pix_cnt_reg     <= '0;
         pixel_grb_reg   <= '0;
         pixel_valid_reg <= 1'b0;
         pixel_index_reg <= '0;
         frame_done_reg  <= 1'b0;
         pixel_count_reg <= '0;
         frame_err_reg   <= 1'b0;
      end else begin
         pixel_valid_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
         if (start_frame) begin
            frame_err_reg <= 1'b0;
            bit_cnt_reg   <= '0;
            pix_cnt_reg   <= '0;
         end
         // The 24th bit publishes the word directly, one cycle after its falling edge.
         if (take_bit) begin
            shift_reg <= shift_next;
            if (bit_cnt_reg == 5'd23) begin
               pixel_grb_reg   <= shift_next;
               pixel_index_reg <= pix_cnt_reg;
               pixel_valid_reg <= 1'b1;
               pix_cnt_reg     <= pix_cnt_reg + 8'd1;
               bit_cnt_reg     <= '0;
            end else begin
               bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
         end
         if (set_err)
            frame_err_reg <= 1'b1;
         if (end_frame) begin
            frame_done_reg  <= 1'b1;
            pixel_count_reg <= pix_cnt_reg;
            bit_cnt_reg     <= '0;
            if (bit_cnt_reg != 5'd0)
               frame_err_reg <= 1'b1;
         end
      end
   end

   assign bus.pixelGRB   = pixel_grb_reg;
   assign bus.pixelValid = pixel_valid_reg;
   assign bus.pixelIndex = pixel_index_reg;
   assign bus.frameDone  = frame_done_reg;
   assign bus.pixelCount = pixel_count_reg;
   assign bus.frameErr   = frame_err_reg;
   assign bus.armed      = (state_reg == IDLE);

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: table of pixel frames plus hand-written
// sequences for partial frames, glitches, stuck-high, pulse-width boundaries and reset.
module tb_ws2812_rx_decoder;

   localparam int T_RESET_TB = 2000;

   logic clk = 1'b0;
   logic reset;

   ws2812_rx_decoder_if bus();

   ws2812_rx_decoder #(
      .T_THRESH (60),
      .T_MINHIGH(20),
      .T_MAXHIGH(120),
      .T_RESET  (T_RESET_TB),
      .CW       (15)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] pv_q[$];
   int          pv_cyc_q[$];
   int          fd_cnt = 0;
   logic [7:0]  fd_pixcount = '0;
   int          last_fall_cyc = 0;
   int          first_fall;

   typedef struct {
      int              npix;
      logic [2:0][23:0] w;
   } frame_vec_t;

   frame_vec_t vecs[3];

   always @(negedge clk) begin
      if (bus.pixelValid) begin
         pv_q.push_back({bus.pixelIndex, bus.pixelGRB});
         pv_cyc_q.push_back(cyc);
         $display("pixel  idx=%0d grb=%06h", bus.pixelIndex, bus.pixelGRB);
      end
      if (bus.frameDone) begin
         fd_cnt++;
         fd_pixcount = bus.pixelCount;
         $display("frame  done pixelCount=%0d frameErr=%0b", bus.pixelCount, bus.frameErr);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic level(input logic v, input int n);
      bus.dataIn = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      if (b) begin
         level(1'b1, 80);
         last_fall_cyc = cyc;
         level(1'b0, 45);
      end else begin
         level(1'b1, 40);
         last_fall_cyc = cyc;
         level(1'b0, 85);
      end
   endtask

   task automatic send_bits(input logic [23:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) send_bit(w[i]);
   endtask

   task automatic clear_mon();
      pv_q.delete();
      pv_cyc_q.delete();
      fd_cnt = 0;
   endtask

   initial begin
      vecs[0].npix = 1; vecs[0].w[0] = 24'hA53C0F; vecs[0].w[1] = '0;         vecs[0].w[2] = '0;
      vecs[1].npix = 3; vecs[1].w[0] = 24'hFF0000; vecs[1].w[1] = 24'h00FF00; vecs[1].w[2] = 24'h0000FF;
      vecs[2].npix = 2; vecs[2].w[0] = 24'h800001; vecs[2].w[1] = 24'h7FFFFE; vecs[2].w[2] = '0;

      reset = 1'b1;
      bus.dataIn = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_grb", {8'h0, bus.pixelGRB}, 32'h0);
      check("reset_flags", {bus.pixelIndex, bus.pixelCount, 3'b0, bus.pixelValid, bus.frameDone,
                            bus.frameErr, bus.armed}, 32'h0);
      reset = 1'b0;
      level(1'b0, T_RESET_TB - 10);
      check("arm_early", {31'h0, bus.armed}, 32'h0);
      level(1'b0, 20);
      check("arm_late", {31'h0, bus.armed}, 32'h1);
      check("arm_no_frame", fd_cnt, 0);
      check("arm_no_pixel", pv_q.size(), 0);
      $display("startup  armed after reset code");

      for (int v = 0; v < 3; v++) begin
         clear_mon();
         first_fall = 0;
         for (int p = 0; p < vecs[v].npix; p++) begin
            send_bits(vecs[v].w[p], 23, 0);
            if (p == 0) first_fall = last_fall_cyc;
         end
         level(1'b0, T_RESET_TB + 50);
         check("vec_pix_n", pv_q.size(), vecs[v].npix);
         for (int p = 0; p < vecs[v].npix && p < pv_q.size(); p++)
            check("vec_pix_word", pv_q[p], {8'(p), vecs[v].w[p]});
         if (pv_cyc_q.size() > 0)
            check("vec_pix_latency", pv_cyc_q[0] - first_fall, 3);
         check("vec_frame_n", fd_cnt, 1);
         check("vec_pixcount", {24'h0, fd_pixcount}, vecs[v].npix);
         check("vec_frame_err", {31'h0, bus.frameErr}, 32'h0);
         check("vec_armed", {31'h0, bus.armed}, 32'h1);
         check("vec_grb_hold", {8'h0, bus.pixelGRB}, {8'h0, vecs[v].w[vecs[v].npix-1]});
         $display("vector %0d  %0d pixels sent", v, vecs[v].npix);
      end

      clear_mon();
      send_bits(24'hABCDEF, 23, 14);
      level(1'b0, T_RESET_TB + 50);
      check("part_pix_n", pv_q.size(), 0);
      check("part_frame_n", fd_cnt, 1);
      check("part_pixcount", {24'h0, fd_pixcount}, 32'h0);
      check("part_frame_err", {31'h0, bus.frameErr}, 32'h1);
      check("part_grb_hold", {8'h0, bus.pixelGRB}, 32'h007FFFFE);
      $display("partial  10 bits then reset code");

      clear_mon();
      level(1'b1, 5);
      check("err_clear_on_rise", {31'h0, bus.frameErr}, 32'h0);
      level(1'b1, 55);
      level(1'b0, 60);
      level(1'b1, 59);
      level(1'b0, 60);
      level(1'b1, 20);
      level(1'b0, 60);
      send_bits(24'h955555, 20, 0);
      level(1'b0, T_RESET_TB + 50);
      check("bnd_pix_n", pv_q.size(), 1);
      if (pv_q.size() > 0) check("bnd_pix_word", pv_q[0], 32'h00955555);
      check("bnd_frame_n", fd_cnt, 1);
      check("bnd_pixcount", {24'h0, fd_pixcount}, 32'h1);
      check("bnd_frame_err", {31'h0, bus.frameErr}, 32'h0);
      $display("boundary  widths 60/59/20 decoded");

      clear_mon();
      send_bits(24'hF0F0F0, 23, 19);
      level(1'b1, 10);
      level(1'b0, 20);
      check("glitch_err", {31'h0, bus.frameErr}, 32'h1);
      check("glitch_unarmed", {31'h0, bus.armed}, 32'h0);
      level(1'b0, T_RESET_TB - 100);
      check("glitch_still_unarmed", {31'h0, bus.armed}, 32'h0);
      level(1'b0, 150);
      check("glitch_rearmed", {31'h0, bus.armed}, 32'h1);
      check("glitch_no_frame", fd_cnt, 0);
      check("glitch_no_pixel", pv_q.size(), 0);
      check("glitch_err_sticky", {31'h0, bus.frameErr}, 32'h1);
      $display("glitch  10-cycle pulse");

      clear_mon();
      level(1'b1, 130);
      check("stuck_err", {31'h0, bus.frameErr}, 32'h1);
      check("stuck_unarmed", {31'h0, bus.armed}, 32'h0);
      level(1'b0, T_RESET_TB + 50);
      check("stuck_rearmed", {31'h0, bus.armed}, 32'h1);
      check("stuck_no_frame", fd_cnt, 0);
      $display("stuck  130-cycle high");

      clear_mon();
      check("pre_rst_pixcount", {24'h0, bus.pixelCount}, 32'h1);
      send_bits(24'h123456, 23, 0);
      level(1'b1, 30);
      check("pre_rst_grb", {8'h0, bus.pixelGRB}, 32'h00123456);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_grb", {8'h0, bus.pixelGRB}, 32'h0);
      check("midrst_flags", {bus.pixelIndex, bus.pixelCount, 3'b0, bus.pixelValid, bus.frameDone,
                             bus.frameErr, bus.armed}, 32'h0);
      reset = 1'b0;
      fd_cnt = 0;
      level(1'b0, T_RESET_TB + 20);
      check("midrst_rearmed", {31'h0, bus.armed}, 32'h1);
      check("midrst_no_frame", fd_cnt, 0);
      $display("midreset  reset asserted mid-pixel");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ws2812_rx_decoder.md
Name: ws2812_rx_decoder

Overview:
- Receiver end of the WS2812B NZR link: samples a single-wire NZR stream (e.g. the dataOut of our LED-strip transmitter), decodes each bit from its high-pulse width and assembles 24-bit GRB pixel words, MSB first.
- Detects the >280 us reset code as end of frame and reports pixel count and framing errors.
- Used as a loopback checker for the transmitter and as the input stage of game logic that reads a strip stream.

Parameters:
- T_THRESH, 60, high-time cycles at or above which a bit decodes as 1 (0.6 us at 100 MHz).
- T_MINHIGH, 20, minimum legal high time in cycles; shorter is a glitch error.
- T_MAXHIGH, 120, maximum legal high time in cycles; reaching it is a stuck-high error.
- T_RESET, 28000, low-time cycles that constitute a reset code (280 us).
- CW, 15, width of the pulse-timing counter; must hold T_RESET.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- dataIn  in  1  NZR serial input, may be asynchronous
- pixelGRB  out  24  last completed pixel word {G[7:0],R[7:0],B[7:0]}
- pixelValid  out  1  one-cycle pulse: pixelGRB/pixelIndex updated this cycle
- pixelIndex  out  8  0-based index of the pixel in pixelGRB within the current frame
- frameDone  out  1  one-cycle pulse at end of frame (reset code detected)
- pixelCount  out  8  pixels completed in the last finished frame; valid from frameDone onward
- frameErr  out  1  sticky error level; cleared at the first rising edge of the next frame
- armed  out  1  high in IDLE, meaning the decoder is ready to accept a frame

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: all outputs are 0; state is WAIT_RST; counters and shift register are cleared.
- A reset mid-frame discards all partial data. No frameDone is produced.
- Input sync: dataIn passes through a 2-flop synchronizer to give dS.
  - Edges are detected on dS versus its 1-cycle delayed copy.
  - All latencies below are stated relative to dS; add 2 cycles relative to dataIn.
- tcnt: CW-bit counter, cleared on every dS edge, incremented each cycle, saturates at T_RESET.
- WAIT_RST:
  - Any high level clears tcnt.
  - When tcnt reaches T_RESET with dS low, go to IDLE. No frameDone is produced.
- IDLE:
  - armed=1.
  - Rising edge: go to HIGH, clear frameErr, clear bitCnt (0..23), clear pixCnt.
- HIGH:
  - Falling edge with tcnt < T_MINHIGH: set frameErr, go to WAIT_RST.
  - Falling edge otherwise: bit = (tcnt >= T_THRESH). Shift the bit into the LSB of the 24-bit shift register and increment bitCnt. Go to LOW.
  - tcnt reaching T_MAXHIGH: set frameErr, go to WAIT_RST.
- Pixel completion: occurs on the falling-edge cycle in which bitCnt was 23.
  - Next cycle: pixelGRB = shift register, pixelIndex = pixCnt, pixelValid=1.
  - In the same cycle, pixCnt increments and bitCnt returns to 0.
  - This gives 1 cycle of latency from the falling edge of bit 23.
- pixCnt wraps modulo 256; no error is flagged on wrap.
- LOW:
  - Rising edge: go to HIGH (next bit).
  - tcnt reaching T_RESET: frameDone=1 for one cycle and pixelCount = pixCnt, then go to IDLE.
  - If bitCnt != 0 at that point (partial pixel), also set frameErr. The partial bits are discarded.
- Simultaneous events: an error and a frameDone cannot coincide. Error paths bypass the frameDone output.
- pixelGRB and pixelIndex hold their values until the next pixelValid.
- No low-time upper bound is checked between bits, other than the reset code.

Test Plan:
- Reset, hold dataIn low for 28010 cycles -> armed=1 after T_RESET+2; no frameDone, no pixelValid.
- From IDLE, send one pixel 0xA5_3C_0F (1 = 80H/45L, 0 = 40H/85L), then low for 28000 cycles -> pixelValid once with pixelGRB=0xA53C0F, pixelIndex=0; frameDone with pixelCount=1; frameErr=0.
- Send 3 pixels 0xFF0000, 0x00FF00, 0x0000FF back-to-back, then a reset code -> three pixelValid pulses, indices 0,1,2, exact words; pixelCount=3.
- Send 10 bits, then a reset code -> no pixelValid; frameDone with pixelCount=0; frameErr=1. The next frame's first rising edge clears frameErr.
- Send a 10-cycle high glitch mid-pixel, or hold high for 130 cycles -> frameErr=1 and armed=0 until 28000 low cycles; no frameDone.
- Boundary pulse widths of 59 and 60 high cycles decode as 0 and 1. Assert reset mid-pixel -> all outputs return to 0 on the next clk.
